// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one backing-memory port between the instruction-fetch stage (IF)
// and the data-memory stage (DM). One requester is granted at a time. The
// arbiter drives the memory port until mem_ack. It then returns the read
// data with a one-cycle done pulse to the owner.
//
// Transaction shape (minimum latency, no wait states):
//   cycle N   : IDLE, request sampled, winner's address/we/wdata latched
//   cycle N+1 : BUS_IF / BUS_DM, mem_req=1 (plus one cycle per wait state)
//   cycle N+2 : RESP, owner's done=1 with rdata valid
//   cycle N+3 : IDLE again, requester may present a new request
//
// Arbitration:
//   Default build: DM wins over IF when both request, because a DM request
//   belongs to the older instruction.
//   `define MEM_ARB_ROUND_ROBIN_EN: a one-bit last-grant flag breaks ties
//   in favour of the requester that was not granted last. The flag resets
//   to "fetch", so the first tie goes to DM.
//
// Parameters:
//   BUS_DATA_WIDTH  width of the address and data buses (default 64)
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   if_req, if_addr       fetch request and address (fetch is always a read)
//   if_rdata, if_done     fetch read data and completion pulse (registered)
//   dm_req, dm_we,
//   dm_addr, dm_wdata     data-memory request, write enable, address, store data
//   dm_rdata, dm_done     load data and completion pulse (registered)
//   mem_req, mem_we,
//   mem_addr, mem_wdata   memory port, driven from the transaction registers
//   mem_ack, mem_rdata    memory completion and read data
//   if_stall, dm_stall    combinational: req high and done low
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      if_req,
  input  logic [BUS_DATA_WIDTH-1:0] if_addr,
  output logic [BUS_DATA_WIDTH-1:0] if_rdata,
  output logic                      if_done,

  input  logic                      dm_req,
  input  logic                      dm_we,
  input  logic [BUS_DATA_WIDTH-1:0] dm_addr,
  input  logic [BUS_DATA_WIDTH-1:0] dm_wdata,
  output logic [BUS_DATA_WIDTH-1:0] dm_rdata,
  output logic                      dm_done,

  output logic                      mem_req,
  output logic                      mem_we,
  output logic [BUS_DATA_WIDTH-1:0] mem_addr,
  output logic [BUS_DATA_WIDTH-1:0] mem_wdata,
  input  logic                      mem_ack,
  input  logic [BUS_DATA_WIDTH-1:0] mem_rdata,

  output logic                      if_stall,
  output logic                      dm_stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUS_IF = 2'd1,
    BUS_DM = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;

  // Winner of the arbitration in IDLE. This is only meaningful when at least
  // one request is present; the FSM checks if_req for the fetch branch.
  logic grant_dm;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = the last grant went to DM, 0 = the last grant went to fetch.
  logic last_grant_dm;

  // A lone request always wins. On a tie, grant the side that was not
  // granted last.
  always_comb begin
    grant_dm = dm_req && (!if_req || !last_grant_dm);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_dm <= 1'b0;
    end else if (state == IDLE && (if_req || dm_req)) begin
      last_grant_dm <= grant_dm;
    end
  end
`else
  // Fixed priority: the older instruction (DM) always wins.
  always_comb begin
    grant_dm = dm_req;
  end
`endif

  // The stall outputs follow the inputs combinationally, so a requester
  // sees the stall in the same cycle it raises req.
  assign if_stall = if_req && !if_done;
  assign dm_stall = dm_req && !dm_done;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples the values from before the edge.
  // Read-data registers are reset as well, because they are module outputs
  // with a defined reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Any mem_ack seen here is stray and is ignored.
          if (grant_dm) begin
            state     <= BUS_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (if_req) begin
            state     <= BUS_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end

        BUS_IF: begin
          // There is no timeout: the port is held until the memory answers.
          if (mem_ack) begin
            state    <= RESP;
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
          end
        end

        BUS_DM: begin
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            dm_done <= 1'b1;
            // A store returns no data, so the last load value is kept.
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end
        end

        RESP: begin
          // Requests are not sampled here. The requester drops or replaces
          // its req only after seeing done, so the next decision happens in
          // IDLE.
          state   <= IDLE;
          if_done <= 1'b0;
          dm_done <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          if_done <= 1'b0;
          dm_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A transaction-level reference
// model tracks which requests are pending. It picks the winner by the
// arbitration rule and predicts the address, write enable and store data on
// the memory port. It also predicts the done pulses and the read data that
// each requester should hold. The memory side answers after a chosen number
// of wait states. A stray mem_ack is driven in every IDLE and RESP cycle.
// Both the macro-defined and the default arbitration rules are modelled.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic         if_req;
  logic [W-1:0] if_addr;
  logic [W-1:0] if_rdata;
  logic         if_done;
  logic         dm_req;
  logic         dm_we;
  logic [W-1:0] dm_addr;
  logic [W-1:0] dm_wdata;
  logic [W-1:0] dm_rdata;
  logic         dm_done;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;
  logic         if_stall;
  logic         dm_stall;

  mem_port_arbiter #(.BUS_DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .if_stall  (if_stall),
    .dm_stall  (dm_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (transaction level).
  bit           p_if, p_dm;            // pending requests
  logic [W-1:0] q_if_addr;
  bit           q_dm_we;
  logic [W-1:0] q_dm_addr, q_dm_wdata;
  logic [W-1:0] exp_if_rdata, exp_dm_rdata;
  bit           m_last_dm;             // last grant went to DM

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    p_if         = 1'b0;
    p_dm         = 1'b0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    m_last_dm    = 1'b0;
  endtask

  // One arbitration round, starting with the DUT in IDLE just after an edge.
  // A new request is added only for a side that has nothing pending.
  // "waits" is the number of memory wait states; rd is the data returned
  // with mem_ack.
  task automatic run_round(input bit new_if, input logic [W-1:0] ia,
                           input bit new_dm, input bit dwe,
                           input logic [W-1:0] da, input logic [W-1:0] dwd,
                           input int waits, input logic [W-1:0] rd);
    bit win_dm;
    logic [W-1:0] exp_addr;
    if (new_if && !p_if) begin
      p_if      = 1'b1;
      q_if_addr = ia;
    end
    if (new_dm && !p_dm) begin
      p_dm       = 1'b1;
      q_dm_we    = dwe;
      q_dm_addr  = da;
      q_dm_wdata = dwd;
    end
    if_req    = p_if;
    if_addr   = q_if_addr;
    dm_req    = p_dm;
    dm_we     = q_dm_we;
    dm_addr   = q_dm_addr;
    dm_wdata  = q_dm_wdata;
    mem_ack   = 1'b1;                  // stray ack in IDLE
    mem_rdata = rnd64();
    #1;
    check("idle_mem_req", 64'(mem_req), 64'd0);
    check("idle_if_done", 64'(if_done), 64'd0);
    check("idle_dm_done", 64'(dm_done), 64'd0);
    check("idle_if_stall", 64'(if_stall), 64'(p_if));
    check("idle_dm_stall", 64'(dm_stall), 64'(p_dm));
    check("idle_if_rdata", if_rdata, exp_if_rdata);
    check("idle_dm_rdata", dm_rdata, exp_dm_rdata);
    if (!p_if && !p_dm) begin
      tick();
      return;
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie, the side that did not win last time gets the port.
    if (p_if && p_dm) win_dm = !m_last_dm;
    else              win_dm = p_dm;
`else
    win_dm = p_dm;
`endif
    m_last_dm = win_dm;
    exp_addr  = win_dm ? q_dm_addr : q_if_addr;

    tick();
    for (int i = 0; i <= waits; i++) begin
      mem_ack   = (i == waits);
      mem_rdata = (i == waits) ? rd : rnd64();
      #1;
      check("bus_mem_req", 64'(mem_req), 64'd1);
      check("bus_mem_addr", mem_addr, exp_addr);
      check("bus_mem_we", 64'(mem_we), 64'(win_dm && q_dm_we));
      if (win_dm && q_dm_we) check("bus_mem_wdata", mem_wdata, q_dm_wdata);
      check("bus_if_done", 64'(if_done), 64'd0);
      check("bus_dm_done", 64'(dm_done), 64'd0);
      check("bus_if_stall", 64'(if_stall), 64'(p_if));
      check("bus_dm_stall", 64'(dm_stall), 64'(p_dm));
      tick();
    end

    if (win_dm) begin
      if (!q_dm_we) exp_dm_rdata = rd;
    end else begin
      exp_if_rdata = rd;
    end

    // RESP cycle: owner's done pulse, stray ack ignored.
    mem_ack   = 1'b1;
    mem_rdata = rnd64();
    #1;
    check("resp_mem_req", 64'(mem_req), 64'd0);
    check("resp_if_done", 64'(if_done), 64'(!win_dm));
    check("resp_dm_done", 64'(dm_done), 64'(win_dm));
    check("resp_if_rdata", if_rdata, exp_if_rdata);
    check("resp_dm_rdata", dm_rdata, exp_dm_rdata);
    check("resp_if_stall", 64'(if_stall), 64'(p_if && win_dm));
    check("resp_dm_stall", 64'(dm_stall), 64'(p_dm && !win_dm));
    if (win_dm) p_dm = 1'b0;
    else        p_if = 1'b0;
    tick();
  endtask

  // Finish any transaction that is still pending.
  task automatic drain();
    for (int k = 0; k < 4 && (p_if || p_dm); k++) begin
      run_round(1'b0, '0, 1'b0, 1'b0, '0, '0, $urandom_range(0, 2), rnd64());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    model_reset();
    q_if_addr  = '0;
    q_dm_we    = 1'b0;
    q_dm_addr  = '0;
    q_dm_wdata = '0;

    #12;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_if_done", 64'(if_done), 64'd0);
    check("rst_dm_done", 64'(dm_done), 64'd0);
    check("rst_if_rdata", if_rdata, 64'd0);
    check("rst_dm_rdata", dm_rdata, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Both sides re-request back-to-back. The first tie after reset goes
    // to DM; with round robin the order then alternates.
    for (int i = 0; i < 4; i++) begin
      run_round(1'b1, 64'h1000 + 64'(i), 1'b1, 1'b0, 64'h2000 + 64'(i), '0,
                0, 64'hA000 + 64'(i));
    end
    drain();

    // Single fetch, ack in the first bus cycle.
    run_round(1'b1, 64'h40, 1'b0, 1'b0, '0, '0, 0, 64'hDEAD);
    // Store with two wait states; dm_rdata must stay unchanged.
    run_round(1'b0, '0, 1'b1, 1'b1, 64'h100, 64'h1234, 2, rnd64());
    // Simultaneous requests.
    run_round(1'b1, 64'h10, 1'b1, 1'b0, 64'h20, '0, 1, 64'hAAAA);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      run_round($urandom_range(0, 2) != 0, rnd64(),
                $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                rnd64(), rnd64(), $urandom_range(0, 3), rnd64());
    end
    drain();

    // Make dm_rdata non-zero, then reset in the middle of a DM transaction.
    run_round(1'b0, '0, 1'b1, 1'b0, 64'h300, '0, 0, 64'hCAFE_F00D);
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 64'h200;
    mem_ack = 1'b0;
    tick();
    #1;
    check("mid_mem_req", 64'(mem_req), 64'd1);
    reset = 1'b1;
    #1;
    check("arst_mem_req", 64'(mem_req), 64'd0);
    check("arst_dm_done", 64'(dm_done), 64'd0);
    check("arst_dm_rdata", dm_rdata, 64'd0);
    check("arst_mem_addr", mem_addr, 64'd0);
    dm_req = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_round(1'b1, 64'h80, 1'b0, 1'b0, '0, '0, 1, 64'hBEEF);
    run_round(1'b1, 64'h84, 1'b1, 1'b1, 64'h88, 64'h55, 0, rnd64());
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
